// File: rtl/demux_1x8_dispatcher.sv
// ---------------------------------------------------------------------------
// demux_1x8_dispatcher
//   Round-robin scheduler that owns the select of a downstream 1x8 demux.
//   A single valid/ready input stream is accepted one beat at a time. The
//   beat is held and presented on exactly one lane, picked by rotating from
//   the last served lane and skipping lanes masked off by ch_en.
//
// Handshake rules (both sides): a beat moves on a rising edge where valid
// and ready are both high. Once valid is raised it stays up, with data
// stable, until that edge. Ready is allowed to depend on state and ch_en
// but never on valid.
//
// Optional feature (macro DEMUX_REROUTE_EN):
//   When the held lane stalls for TIMEOUT cycles, the beat moves to the next
//   enabled lane and reroute pulses for one cycle. Without the macro the beat
//   is held indefinitely and reroute is tied low.
//
// Parameters
//   W        data width
//   TIMEOUT  stall cycles before reroute (reroute build only, >= 2)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   ch_en      in   [7:0] lane enable mask
//   in_valid   in   input beat present
//   in_data    in   [W-1:0] input beat
//   in_ready   out  a beat can be accepted this cycle
//   sel        out  [2:0] lane currently holding the beat
//   out_valid  out  [7:0] one-hot, bit sel high while a beat is held
//   out_data   out  [W-1:0] held beat, shared by all lanes
//   out_ready  in   [7:0] per-lane ready, only bit sel is observed
//   reroute    out  one-cycle pulse when a stalled beat changes lane
// ---------------------------------------------------------------------------
module demux_1x8_dispatcher #(
   parameter int W       = 8,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   ch_en,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic [2:0]   sel,
   output logic [7:0]   out_valid,
   output logic [W-1:0] out_data,
   input  logic [7:0]   out_ready,
   output logic         reroute
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t     state;
   logic [2:0] ptr;        // last lane served; the next search starts one lane past it
   logic [2:0] grant_lane;

   // First lane set in mask, searching base+1, base+2, ... base+8 (mod 8).
   // The loop runs from the far end so the nearest hit is the one that sticks.
   function automatic logic [2:0] next_lane(input logic [2:0] base,
                                            input logic [7:0] mask);
      logic [2:0] res;
      logic [2:0] idx;
      res = base;
      for (int k = 8; k >= 1; k--) begin
         idx = base + 3'(k);
         if (mask[idx]) res = idx;
      end
      return res;
   endfunction

   assign grant_lane = next_lane(ptr, ch_en);
   assign in_ready   = (state == IDLE) && (|ch_en);

`ifdef DEMUX_REROUTE_EN
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] STALL_MAX = CW'(TIMEOUT - 1);

   logic [CW-1:0] stall;
   logic [7:0]    other_en;
   logic [2:0]    alt_lane;

   // Enabled lanes other than the one holding the beat.
   assign other_en = ch_en & ~(8'b1 << sel);
   assign alt_lane = next_lane(sel, other_en);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 3'd7;
         sel       <= 3'd0;
         out_valid <= 8'd0;
         out_data  <= '0;
         reroute   <= 1'b0;
         stall     <= '0;
      end else begin
         reroute <= 1'b0;
         case (state)
            IDLE: begin
               stall <= '0;
               if (in_valid && in_ready) begin
                  out_data  <= in_data;
                  sel       <= grant_lane;
                  out_valid <= 8'b1 << grant_lane;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready[sel]) begin
                  ptr       <= sel;
                  out_valid <= 8'd0;
                  stall     <= '0;
                  state     <= IDLE;
               end else if (stall == STALL_MAX) begin
                  // With no alternative lane the counter simply stays saturated.
                  if (|other_en) begin
                     sel       <= alt_lane;
                     out_valid <= 8'b1 << alt_lane;
                     reroute   <= 1'b1;
                     stall     <= '0;
                  end
               end else begin
                  stall <= stall + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 3'd7;
         sel       <= 3'd0;
         out_valid <= 8'd0;
         out_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  out_data  <= in_data;
                  sel       <= grant_lane;
                  out_valid <= 8'b1 << grant_lane;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready[sel]) begin
                  ptr       <= sel;
                  out_valid <= 8'd0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign reroute = 1'b0;
`endif

endmodule

// File: tb/tb_demux_1x8_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_demux_1x8_dispatcher
//   Directed bench for demux_1x8_dispatcher. Inputs are driven 1 ns after
//   the rising edge, and outputs are sampled in that same settled window.
//   Define DEMUX_REROUTE_EN to also run the reroute scenarios. The DUT is
//   then built with TIMEOUT=4.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demux_1x8_dispatcher;

   localparam int W = 8;
`ifdef DEMUX_REROUTE_EN
   localparam int TMO     = 4;
   localparam int STALL_N = 3;   // stays below the reroute threshold
`else
   localparam int TMO     = 16;
   localparam int STALL_N = 5;
`endif

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   ch_en;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic [2:0]   sel;
   logic [7:0]   out_valid;
   logic [W-1:0] out_data;
   logic [7:0]   out_ready;
   logic         reroute;

   always #5 clk = ~clk;

   demux_1x8_dispatcher #(.W(W), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .ch_en     (ch_en),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .reroute   (reroute)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat. Expect it to be taken at the next edge and to land on
   // lane exp_lane.
   task automatic accept(input logic [W-1:0] data, input logic [2:0] exp_lane);
      in_valid = 1'b1;
      in_data  = data;
      #1;
      check("in_ready_idle", in_ready, 1);
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      #1;
      check("sel_grant", sel, exp_lane);
      check("out_valid_grant", out_valid, 8'b1 << exp_lane);
      check("out_data_grant", out_data, data);
      check("in_ready_hold", in_ready, 0);
   endtask

   // Next edge must complete the handshake on the held lane.
   task automatic expect_release();
      tick();
      check("out_valid_release", out_valid, 0);
      check("in_ready_release", in_ready, (ch_en != 0) ? 1 : 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst       = 1'b1;
      ch_en     = 8'hFF;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 8'hFF;
      tick();
      tick();
      rst = 1'b0;
      #1;

      // reset state
      check("rst_sel", sel, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_reroute", reroute, 0);
      check("rst_in_ready", in_ready, 1);

      // 1: all lanes, all ready -> lanes 0..7 in order, one beat per 2 cycles
      for (int i = 0; i < 8; i++) begin
         accept(W'(8'h10 + i), 3'(i));
         expect_release();
      end

      // 2: sparse mask 1010_0100 from ptr=7 -> 2,5,7,2
      ch_en = 8'b1010_0100;
      accept(8'h21, 3'd2); expect_release();
      accept(8'h22, 3'd5); expect_release();
      accept(8'h23, 3'd7); expect_release();
      accept(8'h24, 3'd2); expect_release();
      // all lanes disabled: nothing accepted
      ch_en    = 8'h00;
      in_valid = 1'b1;
      in_data  = 8'hEE;
      #1;
      check("in_ready_no_lanes", in_ready, 0);
      tick();
      tick();
      check("out_valid_no_lanes", out_valid, 0);
      check("in_ready_no_lanes2", in_ready, 0);
      in_valid = 1'b0;

      // 3: ptr=2, hold on lane 3 with its ready low, other lanes ready
      ch_en     = 8'hFF;
      out_ready = 8'hF7;
      accept(8'h33, 3'd3);
      for (int i = 0; i < STALL_N; i++) begin
         if (i == 1) ch_en = 8'hF7;   // lane 3 disabled while holding
         tick();
         check("stall_sel", sel, 3);
         check("stall_out_valid", out_valid, 8'h08);
         check("stall_out_data", out_data, 8'h33);
      end
      out_ready = 8'h08;
      expect_release();
      out_ready = 8'hFF;
      accept(8'h44, 3'd4);   // lane 3 still disabled, next after 3 is 4
      expect_release();

      // 4: reset while holding lane 6 drops the beat
      ch_en     = 8'h40;
      out_ready = 8'h00;
      accept(8'h66, 3'd6);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("rst_hold_out_valid", out_valid, 0);
      check("rst_hold_sel", sel, 0);
      check("rst_hold_out_data", out_data, 0);
      ch_en     = 8'hFF;
      out_ready = 8'hFF;
      accept(8'h70, 3'd0);
      expect_release();

`ifdef DEMUX_REROUTE_EN
      // 5: hold lane 1, only lane 2 ready -> reroute after 4 stall cycles
      out_ready = 8'h04;
      accept(8'h55, 3'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rr_wait_sel", sel, 1);
         check("rr_wait_pulse", reroute, 0);
      end
      tick();
      check("rr_sel", sel, 2);
      check("rr_out_valid", out_valid, 8'h04);
      check("rr_pulse", reroute, 1);
      check("rr_data", out_data, 8'h55);
      expect_release();
      check("rr_pulse_end", reroute, 0);

      // 6: only lane 1 enabled -> no reroute however long it stalls
      ch_en     = 8'h02;
      out_ready = 8'h00;
      accept(8'h61, 3'd1);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("sat_sel", sel, 1);
         check("sat_pulse", reroute, 0);
      end
      out_ready = 8'h02;
      expect_release();
`endif

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
